// File: rtl/sdpram_read_streamer.sv
// sdpram_read_streamer: reads len consecutive words from a simple dual-port
// RAM (port B, 1-cycle registered read) and presents them as a valid/ready
// stream with a last-beat marker. A 2-entry output FIFO (head + skid) absorbs
// read latency and backpressure. Read issue is credit-limited so the FIFO
// never overflows.
module sdpram_read_streamer #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic              enb,
  output logic [ADDR_W-1:0] addrb,
  input  logic [DATA_W-1:0] doutb,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  iss_q, iss_d;
  logic              inflight_q, inflight_d;
  logic              inflight_last_q, inflight_last_d;
  logic              head_valid_q, head_valid_d;
  logic              head_last_q, head_last_d;
  logic [DATA_W-1:0] head_data_q, head_data_d;
  logic              skid_valid_q, skid_valid_d;
  logic              skid_last_q, skid_last_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              pop;
  logic              push;
  logic              issue_last;
  logic [2:0]        used;

  assign pop        = head_valid_q & m_ready;
  assign push       = inflight_q;
  assign issue_last = (iss_q == (len_q - CNT_W'(1)));
  // Slots committed: buffered words plus the read whose data arrives this cycle.
  assign used       = 3'(head_valid_q) + 3'(skid_valid_q) + 3'(inflight_q);

  // Next-state, read issue, and output FIFO update.
  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    len_d           = len_q;
    iss_d           = iss_q;
    inflight_d      = 1'b0;
    inflight_last_d = 1'b0;
    head_valid_d    = head_valid_q;
    head_last_d     = head_last_q;
    head_data_d     = head_data_q;
    skid_valid_d    = skid_valid_q;
    skid_last_d     = skid_last_q;
    skid_data_d     = skid_data_q;
    done_d          = 1'b0;
    enb             = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = FETCH;
            addr_d  = base_addr;
            len_d   = len;
            iss_d   = '0;
          end
        end
      end
      FETCH: begin
        // A slot freed by this cycle's pop can be reused immediately,
        // which is what sustains one beat per cycle.
        if (used < (3'd2 + 3'(pop))) begin
          enb             = 1'b1;
          inflight_d      = 1'b1;
          inflight_last_d = issue_last;
          iss_d           = iss_q + CNT_W'(1);
          addr_d          = (addr_q == ADDR_W'(DEPTH - 1)) ? '0 : addr_q + ADDR_W'(1);
          if (issue_last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && head_last_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop || !head_valid_q) begin
      if (skid_valid_q) begin
        head_valid_d = 1'b1;
        head_data_d  = skid_data_q;
        head_last_d  = skid_last_q;
        skid_valid_d = push;
        skid_data_d  = doutb;
        skid_last_d  = push & inflight_last_q;
      end else begin
        head_valid_d = push;
        head_last_d  = push & inflight_last_q;
        if (push) head_data_d = doutb;
      end
    end else if (push) begin
      skid_valid_d = 1'b1;
      skid_data_d  = doutb;
      skid_last_d  = inflight_last_q;
    end

    busy_d = (state_d != IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      len_q           <= '0;
      iss_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      head_valid_q    <= 1'b0;
      head_last_q     <= 1'b0;
      head_data_q     <= '0;
      skid_valid_q    <= 1'b0;
      skid_last_q     <= 1'b0;
      skid_data_q     <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      len_q           <= len_d;
      iss_q           <= iss_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      head_valid_q    <= head_valid_d;
      head_last_q     <= head_last_d;
      head_data_q     <= head_data_d;
      skid_valid_q    <= skid_valid_d;
      skid_last_q     <= skid_last_d;
      skid_data_q     <= skid_data_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
    end
  end

  // A word arriving with both entries full and nothing leaving would be lost.
  assert property (@(posedge clk) disable iff (!rst_n)
    !(push && head_valid_q && skid_valid_q && !pop));

  assign busy    = busy_q;
  assign done    = done_q;
  assign addrb   = addr_q;
  assign m_valid = head_valid_q;
  assign m_data  = head_data_q;
  assign m_last  = head_last_q;

endmodule

// File: tb/tb_sdpram_read_streamer.sv
// Directed bench for sdpram_read_streamer with a behavioural registered-read RAM.
module tb_sdpram_read_streamer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  base_addr = '0;
  logic [10:0] len = '0;
  logic        busy, done, enb, m_valid, m_last;
  logic [9:0]  addrb;
  logic [15:0] doutb = '0;
  logic [15:0] m_data;
  logic        m_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  sdpram_read_streamer #(.ADDR_W(10), .DATA_W(16), .DEPTH(1024)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .enb(enb), .addrb(addrb), .doutb(doutb),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  always #5 clk = ~clk;

  // RAM contents: word at address a is 16'hC000 | a.
  always @(posedge clk) if (enb) doutb <= 16'hC000 | 16'(addrb);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  32'(busy),    0);
    chk({tag, "_done"},  32'(done),    0);
    chk({tag, "_enb"},   32'(enb),     0);
    chk({tag, "_addrb"}, 32'(addrb),   0);
    chk({tag, "_valid"}, 32'(m_valid), 0);
    chk({tag, "_last"},  32'(m_last),  0);
    chk({tag, "_data"},  32'(m_data),  0);
  endtask

  // mode 0: m_ready always 1; mode 1: m_ready pattern 1,0,0 repeating.
  // inj_idx >= 0 pulses a second start (len=5) at that cycle while busy.
  task automatic run_cmd(input logic [9:0] base, input logic [10:0] n,
                         input int mode, input int inj_idx);
    int issued = 0;
    int popped = 0;
    int idx = 0;
    int first_pop = -1;
    int last_pop = -1;
    logic fin = 1'b0;
    logic held_v = 1'b0;
    logic [15:0] held_d = '0;
    logic held_l = 1'b0;
    @(negedge clk);
    start = 1'b1; base_addr = base; len = n;
    @(negedge clk);
    while (!fin && idx < int'(n) + 64) begin
      if (idx == inj_idx) begin
        start = 1'b1; base_addr = 10'h2A0; len = 11'd5;
      end else begin
        start = 1'b0;
      end
      m_ready = (mode == 0) ? 1'b1 : ((idx % 3) == 0);
      #1;
      if (idx == 0) chk("first_enb", 32'(enb), 1);
      chk("busy_run", 32'(busy), 1);
      chk("done_run", 32'(done), 0);
      if (held_v) begin
        chk("stall_valid", 32'(m_valid), 1);
        chk("stall_data", 32'(m_data), 32'(held_d));
        chk("stall_last", 32'(m_last), 32'(held_l));
      end
      if (enb) begin
        chk("addrb", 32'(addrb), 32'(10'(base + 10'(issued))));
        issued++;
      end
      if (m_valid && m_ready) begin
        if (first_pop < 0) first_pop = idx;
        last_pop = idx;
        chk("data", 32'(m_data), 32'(16'hC000 | 16'(10'(base + 10'(popped)))));
        chk("last", 32'(m_last), 32'(popped == int'(n) - 1));
        popped++;
        if (m_last) fin = 1'b1;
      end
      chk("outstanding", 32'((issued - popped) <= 2), 1);
      held_v = m_valid && !m_ready;
      held_d = m_data;
      held_l = m_last;
      @(negedge clk);
      idx++;
    end
    start = 1'b0;
    #1;
    chk("timeout", 32'(fin), 1);
    chk("beats", 32'(popped), 32'(n));
    chk("issues", 32'(issued), 32'(n));
    chk("done_pulse", 32'(done), 1);
    chk("busy_fall", 32'(busy), 0);
    chk("valid_after", 32'(m_valid), 0);
    chk("enb_after", 32'(enb), 0);
    if (mode == 0) begin
      chk("latency", 32'(first_pop), 2);
      chk("throughput", 32'(last_pop - first_pop), 32'(int'(n) - 1));
    end
    @(negedge clk);
    #1;
    chk("done_clear", 32'(done), 0);
    chk("busy_idle", 32'(busy), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: basic 4-word read at full rate
    run_cmd(10'h010, 11'd4, 0, -1);
    // 2: wrap-around at top of address space
    run_cmd(10'h3FE, 11'd4, 0, -1);
    // 3: backpressure pattern 1,0,0
    run_cmd(10'h080, 11'd8, 1, -1);
    // single-word command: first beat is last
    run_cmd(10'h3FF, 11'd1, 0, -1);

    // 4: zero-length command
    @(negedge clk);
    start = 1'b1; base_addr = 10'h055; len = 11'd0; m_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("len0_done", 32'(done), 1);
    chk("len0_busy", 32'(busy), 0);
    chk("len0_enb", 32'(enb), 0);
    chk("len0_valid", 32'(m_valid), 0);
    @(negedge clk);
    #1;
    chk("len0_done_clear", 32'(done), 0);
    chk("len0_enb2", 32'(enb), 0);
    chk("len0_valid2", 32'(m_valid), 0);

    // 5: start while busy is ignored
    run_cmd(10'h040, 11'd3, 0, 1);

    // full-depth command reads every address once across the wrap
    run_cmd(10'h155, 11'd1024, 0, -1);

    // 6: reset mid-DRAIN with one beat buffered
    @(negedge clk);
    start = 1'b1; base_addr = 10'h100; len = 11'd2; m_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("pre_rst_valid", 32'(m_valid), 1);
    chk("pre_rst_data", 32'(m_data), 32'h0000C100);
    chk("pre_rst_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    repeat (2) begin
      @(negedge clk);
      #1;
      chk("rst_hold_done", 32'(done), 0);
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      #1;
      chk("post_rst_done", 32'(done), 0);
      chk("post_rst_valid", 32'(m_valid), 0);
    end
    run_cmd(10'h200, 11'd3, 0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
